// File: rtl/booth_pkg.sv
// Shared types and radix-4 Booth digit recoding for the sequential multiplier.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // 3-bit windows {A[2i+1], A[2i], A[2i-1]} that select a non-zero digit
  localparam logic [2:0] WIN_P1_LO = 3'b001;
  localparam logic [2:0] WIN_P1_HI = 3'b010;
  localparam logic [2:0] WIN_P2    = 3'b011;
  localparam logic [2:0] WIN_M2    = 3'b100;
  localparam logic [2:0] WIN_M1_LO = 3'b101;
  localparam logic [2:0] WIN_M1_HI = 3'b110;

  function automatic logic signed [2:0] booth_digit(input logic [2:0] win);
    case (win)
      WIN_P1_LO, WIN_P1_HI: return 3'sd1;
      WIN_P2:               return 3'sd2;
      WIN_M2:               return -3'sd2;
      WIN_M1_LO, WIN_M1_HI: return -3'sd1;
      default:              return 3'sd0;
    endcase
  endfunction

endpackage

// File: rtl/booth_seq_ctrl_pp_gen.sv
// Combinational partial-product generator: selects 0/+-B/+-2B for one Booth digit
// and aligns it to bit position 2*idx in the 2W-bit accumulator frame.
module booth_pp_gen
  import booth_pkg::*;
#(
  parameter int W  = 8,
  parameter int IW = 2
) (
  input  logic [2:0]     win_i,
  input  logic [W-1:0]   b_i,
  input  logic [IW-1:0]  idx_i,
  output logic [2*W-1:0] pp_o
);

  logic signed [2:0] dig;
  logic [2*W-1:0]    b_ext;
  logic [2*W-1:0]    mag;

  always_comb begin
    dig   = booth_digit(win_i);
    b_ext = {{W{b_i[W-1]}}, b_i};
    // +-2 is a shift of the sign-extended multiplicand, never a multiply
    case (dig)
      3'sd1:   mag = b_ext;
      3'sd2:   mag = b_ext << 1;
      -3'sd1:  mag = -b_ext;
      -3'sd2:  mag = -(b_ext << 1);
      default: mag = '0;
    endcase
    pp_o = mag << {idx_i, 1'b0};
  end

endmodule

// File: rtl/booth_seq_ctrl.sv
// Sequential signed radix-4 Booth multiplier: accepts an operand pair, retires one
// digit per clock into a 2W-bit accumulator, then holds the product until taken.
module booth_seq_ctrl
  import booth_pkg::*;
#(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_a,
  input  logic [W-1:0]   in_b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] out_p,
  output logic           busy
);

  localparam int N  = W / 2;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, b_q;
  logic [2*W-1:0] acc_q, acc_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] pp;
  logic [W:0]     a_ext;
  logic [2:0]     win;
  logic           accept;
  logic           last_digit;

  assign accept     = in_valid && (state_q == IDLE);
  assign last_digit = (cnt_q == IW'(N - 1));
  assign a_ext      = {a_q, 1'b0};
  assign win        = a_ext[{cnt_q, 1'b0} +: 3];

  booth_pp_gen #(
    .W  (W),
    .IW (IW)
  ) u_pp_gen (
    .win_i (win),
    .b_i   (b_q),
    .idx_i (cnt_q),
    .pp_o  (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = CALC;
      CALC:    if (last_digit) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    out_p     = acc_q;
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (accept) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (state_q == CALC) begin
      acc_d = acc_q + pp;
      if (!last_digit) cnt_d = cnt_q + IW'(1);
    end
  end

  // Operands only load on an accepted handshake; acc persists through IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (accept) begin
        a_q <= in_a;
        b_q <= in_b;
      end
    end
  end

endmodule
